// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg
//   Shared types and helpers for seq_chunk_adder.
//   - state_e      : FSM state encoding (IDLE, ADD, DONE)
//   - idx_width()  : bit width of the chunk index, never less than 1
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // $clog2(1) is 0, so a single-chunk build still needs a 1-bit index.
    function automatic int idx_width(input int num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder
//   Purely combinational CHUNK-bit ripple-carry adder slice.
//   Ports:
//     a, b  : CHUNK-bit addends
//     cin   : carry into bit 0
//     sum   : CHUNK-bit sum
//     cout  : carry out of bit CHUNK-1
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] c;

    // Carry chain kept inside one process so the ripple is evaluated in order.
    always_comb begin
        c   = '0;
        sum = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle WIDTH-bit adder that adds CHUNK bits per clock, LSB slice
//   first, through a single chunk_adder slice. Valid/ready on both sides;
//   one operation in flight at a time.
//
//   Optional feature macro: SEQ_ADDER_OVF_EN adds the signed-overflow
//   output ovf, registered together with co at the final slice.
//
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     in_valid / in_ready   : operand handshake (in_ready only in IDLE)
//     r, s, ci              : addends and carry-in, sampled on accept
//     out_valid / out_ready : result handshake (out_valid only in DONE)
//     out, co               : sum mod 2^WIDTH and carry-out
//     ovf                   : signed overflow (SEQ_ADDER_OVF_EN only)
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | waiting for operands, in_ready high
//   ADD   | adding slice k_q, one slice per clock
//   DONE  | result held, out_valid high until out_ready
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] s,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             co
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int KW         = idx_width(NUM_CHUNKS);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_CHUNKS - 1);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] r_q, s_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             accept;

    logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout;

    assign slice_a = r_q[k_q * CHUNK +: CHUNK];
    assign slice_b = s_q[k_q * CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign accept = (state_q == IDLE) && in_valid;

`ifdef SEQ_ADDER_OVF_EN
    logic ovf_q, ovf_d;
    logic ovf_final;
    // Same-sign operands whose sum flips sign; slice_sum's MSB is out[MSB]
    // on the final slice.
    assign ovf_final = (r_q[WIDTH-1] == s_q[WIDTH-1]) &&
                       (slice_sum[CHUNK-1] != r_q[WIDTH-1]);
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
`ifdef SEQ_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ADD;
                    k_d     = '0;
                    sum_d   = '0;
                    carry_d = ci;
                    co_d    = 1'b0;
`ifdef SEQ_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            ADD: begin
                sum_d[k_q * CHUNK +: CHUNK] = slice_sum;
                carry_d = slice_cout;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    co_d    = slice_cout;
                    state_d = DONE;
`ifdef SEQ_ADDER_OVF_EN
                    ovf_d   = ovf_final;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            r_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            if (accept) begin
                r_q <= r;
                s_q <= s;
            end
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = sum_q;
    assign co        = co_q;

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

- Parametrised, multi-cycle successor to the team's 4-bit parallel adder.
- Adds two WIDTH-bit operands plus carry-in by processing CHUNK bits per clock, LSB slice first, through a single CHUNK-bit adder slice.
- Uses valid/ready handshakes on input and output.
- Sits in datapaths where area matters more than latency, and wherever wide adds must be broken into short carry chains.

## Interface

Parameters:
- WIDTH, 16, operand and sum width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, operands r, s and ci are valid.
- in_ready, output, 1, block accepts operands this cycle.
- r, input, WIDTH, addend A.
- s, input, WIDTH, addend B.
- ci, input, 1, carry-in.
- out_valid, output, 1, out and co hold a completed result.
- out_ready, input, 1, consumer takes the result this cycle.
- out, output, WIDTH, sum = (r + s + ci) mod 2^WIDTH.
- co, output, 1, carry-out of bit WIDTH-1.
- ovf, output, 1, signed overflow; present only with SEQ_ADDER_OVF_EN.

## Operation

- NUM_CHUNKS = WIDTH/CHUNK.
- States: IDLE, ADD, DONE.
- in_ready = (state == IDLE).
- out_valid = (state == DONE).

IDLE:
- When in_valid is high, latch r, s and ci into operand registers.
- Clear chunk index k and the sum register.
- Go to ADD.

ADD, one slice per cycle:
- Slice k = bits [k*CHUNK +: CHUNK].
- Add the slice of r, the slice of s and the running carry (initialised to the latched ci).
- Write the result into the sum slice and update the running carry.
- k increments each cycle.
- After slice NUM_CHUNKS-1: set co to its carry-out and go to DONE.

DONE:
- out, co and ovf are held stable.
- When out_ready is high, go to IDLE.
- No new operands are accepted in DONE: there is no overlap between operations.

Other rules:
- r, s and ci are ignored outside an accepting IDLE cycle. Changing them mid-operation has no effect.
- Arithmetic is unsigned modulo 2^WIDTH; co carries the 2^WIDTH bit.
- CHUNK == WIDTH is legal: ADD lasts exactly one cycle.

## Timing

- Reset, applied at any time including mid-operation:
  - state = IDLE, k = 0.
  - out = 0, co = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 from the first cycle after the reset edge.
  - Any in-flight operation is abandoned and no result is produced.
- Accept edge: the rising edge where in_valid && in_ready.
- out_valid rises exactly NUM_CHUNKS cycles after the accept edge (default parameters: 4 cycles).
- Result handoff: the edge where out_valid && out_ready. in_ready is high in the following cycle.
- Back-to-back throughput: one result per NUM_CHUNKS + 2 cycles, given out_ready = 1 and in_valid = 1.
- in_valid may drop without an accept; nothing is latched.
- out_valid and the result are held until out_ready, for any duration.

## Configuration

- Macro: SEQ_ADDER_OVF_EN.
- Defined:
  - ovf port exists.
  - ovf = (r[MSB] == s[MSB]) && (out[MSB] != r[MSB]), using the latched operands.
  - ovf is registered with co at the final slice.
- Undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

## Structure

- Package seq_adder_pkg holds:
  - state enum type (IDLE, ADD, DONE);
  - function computing the chunk-index width as $clog2(NUM_CHUNKS), minimum 1.
- Sub-module chunk_adder:
  - purely combinational CHUNK-bit ripple adder;
  - ports a, b, cin, sum, cout;
  - one instance in the ADD datapath.
- Top level holds the FSM, operand/sum registers, carry register and handshakes.
- Elaboration-time check: fail if WIDTH % CHUNK != 0.

## Test plan

WIDTH=16, CHUNK=4 unless stated.

1. Basic add:
   - Stimulus: r=0x0002, s=0x0001, ci=0.
   - Response: out_valid 4 cycles after accept; out=0x0003, co=0.
2. Full carry ripple:
   - Stimulus: r=0xFFFF, s=0x0001, ci=0.
   - Response: out=0x0000, co=1.
   - Repeat with r=0x000F, s=0x0000, ci=1 → out=0x0010, co=0.
3. Backpressure:
   - Stimulus: out_ready held low 5 cycles after out_valid.
   - Response: out, co and out_valid stable throughout; in_ready=0 until one cycle after handoff.
4. Reset mid-operation:
   - Stimulus: assert rst in ADD cycle 2.
   - Response: next cycle out_valid=0, out=0, co=0, in_ready=1; the next transaction (0x1234+0x4321) gives 0x5555.
5. Parameter sweep:
   - Stimulus: CHUNK ∈ {1, 4, 16}, WIDTH=16; 200 random operands, back-to-back.
   - Response: result matches r+s+ci; latency equals WIDTH/CHUNK.
6. Overflow (SEQ_ADDER_OVF_EN defined):
   - r=0x7FFF, s=0x0001 → out=0x8000, ovf=1, co=0.
   - r=0x8000, s=0x8000 → out=0x0000, ovf=1, co=1.
